// File: rtl/merge1_leaf_sync.sv
// rtl/merge1_leaf_sync.sv - clocked 2:1 merge leaf with round-robin grant and source tag channel
// The loser of a contention wins the next one; the held entry drains independently on out and s.
module merge1_leaf_sync #(
  parameter int W       = 9,
  parameter bit RR_INIT = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         s_data,
  output logic         s_valid,
  input  logic         s_ready
);

  logic prio;
  logic free;
  logic grant0;
  logic grant1;

  // Ready-through: the entry may be reloaded in the cycle its last handshake completes.
  assign free = ~RESET & (~out_valid | out_ready) & (~s_valid | s_ready);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (free) begin
      if (in0_valid && in1_valid) begin
        grant0 = ~prio;
        grant1 = prio;
      end else begin
        grant0 = in0_valid;
        grant1 = in1_valid;
      end
    end
  end

  assign in0_ready = grant0;
  assign in1_ready = grant1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      s_data    <= 1'b0;
      s_valid   <= 1'b0;
      prio      <= RR_INIT;
    end else if (grant0 || grant1) begin
      out_data  <= grant1 ? in1_data : in0_data;
      s_data    <= grant1;
      out_valid <= 1'b1;
      s_valid   <= 1'b1;
      prio      <= grant0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (s_valid && s_ready)     s_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_merge1_leaf_sync.sv
// tb/tb_merge1_leaf_sync.sv - scoreboard bench for merge1_leaf_sync
module tb_merge1_leaf_sync;

  localparam int W       = 9;
  localparam bit RR_INIT = 1'b0;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         in0_valid, in0_ready, in1_valid, in1_ready;
  logic         out_valid, out_ready, s_data, s_valid, s_ready;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_out[$];
  logic         exp_s[$];
  logic         prio_m;

  always #5 CLK = ~CLK;

  merge1_leaf_sync #(.W(W), .RR_INIT(RR_INIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called shortly after a falling edge with inputs already driven; advances one clock.
  task automatic step();
    bit ov_m, sv_m, fr, g0, g1;
    #1;
    ov_m = (exp_out.size() != 0);
    sv_m = (exp_s.size() != 0);
    fr   = (!ov_m || out_ready) && (!sv_m || s_ready);
    g0   = fr && in0_valid && (!in1_valid || !prio_m);
    g1   = fr && in1_valid && (!in0_valid || prio_m);
    chk("in0_ready", 16'(in0_ready), 16'(g0));
    chk("in1_ready", 16'(in1_ready), 16'(g1));
    chk("out_valid", 16'(out_valid), 16'(ov_m));
    chk("s_valid",   16'(s_valid),   16'(sv_m));
    if (ov_m) chk("out_data", 16'(out_data), 16'(exp_out[0]));
    if (sv_m) chk("s_data",   16'(s_data),   16'(exp_s[0]));
    if (ov_m && out_ready) void'(exp_out.pop_front());
    if (sv_m && s_ready)   void'(exp_s.pop_front());
    if (g0 || g1) begin
      exp_out.push_back(g1 ? in1_data : in0_data);
      exp_s.push_back(g1);
      prio_m = g0;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_s_valid",   16'(s_valid),   16'd0);
    chk("rst_out_data",  16'(out_data),  16'd0);
    chk("rst_s_data",    16'(s_data),    16'd0);
    chk("rst_in0_ready", 16'(in0_ready), 16'd0);
    chk("rst_in1_ready", 16'(in1_ready), 16'd0);
    exp_out.delete();
    exp_s.delete();
    prio_m = RR_INIT;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    in0_data = '0; in1_data = '0; in0_valid = 1'b0; in1_valid = 1'b0;
    out_ready = 1'b1; s_ready = 1'b1;
    prio_m = RR_INIT;
    @(negedge CLK);
    do_reset();

    // single source
    in0_valid = 1'b1; in0_data = 9'h1A5;
    step();
    in0_valid = 1'b0;
    #1 chk("single_out_data", 16'(out_data), 16'h1A5);
    chk("single_s_data", 16'(s_data), 16'd0);
    step();

    // reset mid-run with an item held, then normal acceptance
    in1_valid = 1'b1; in1_data = 9'h033; out_ready = 1'b0; s_ready = 1'b0;
    step();
    in1_valid = 1'b0;
    step();
    do_reset();
    out_ready = 1'b1; s_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 9'h0A5;
    step();
    in0_valid = 1'b0;
    step();
    step();

    // contention from a fresh reset
    do_reset();
    in0_valid = 1'b1; in0_data = 9'h011;
    in1_valid = 1'b1; in1_data = 9'h122;
    for (int i = 0; i < 8; i++) step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();
    step();

    // split sinks: s drains first, out held
    in1_valid = 1'b1; in1_data = 9'h055;
    step();
    in1_valid = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 9'h0A1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    step();
    in0_valid = 1'b0;
    step();
    step();

    // reverse split: out drains first, s held
    in1_valid = 1'b1; in1_data = 9'h0C3;
    step();
    in1_valid = 1'b0; s_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 9'h0B2;
    step();
    step();
    s_ready = 1'b1;
    step();
    in0_valid = 1'b0;
    step();
    step();

    // back-pressure then release
    in0_valid = 1'b1; in0_data = 9'h0D4;
    in1_valid = 1'b1; in1_data = 9'h0E5;
    out_ready = 1'b0; s_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b1; s_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
